hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Stall and bubble generator for the 5-stage MIPS pipeline; the producer side of the `stall` input consumed by the stall-capable pipeline registers.
- Detects load-use hazards between the D and E stages.
- Tracks the multi-cycle HI/LO unit (mult/div) and holds dependent instructions in D until it finishes.
- Drives `stall` (PC register and F/D register) and `flush_e` (D/E register clear), and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).
- PERF_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset).
- D_rs  in  5  rs field of the instruction in D.
- D_rt  in  5  rt field of the instruction in D.
- D_use_rs  in  1  instruction in D reads rs.
- D_use_rt  in  1  instruction in D reads rt.
- D_md_use  in  1  instruction in D is mfhi/mflo/mthi/mtlo/mult/div (needs the HI/LO unit).
- E_load  in  1  instruction in E is a load.
- E_regwrite  in  1  instruction in E writes the register file.
- E_wa  in  5  destination register of the instruction in E.
- E_md_start  in  1  mult/div issuing from E this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  freeze PC and F/D register.
- flush_e  out  1  clear D/E register (bubble).
- md_busy  out  1  HI/LO unit busy.
- busy_cnt  out  CNT_W  remaining busy cycles.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy_cnt=0, stall_cycles=0.
  - stall=0, flush_e=0, md_busy=0, forced regardless of the other inputs.
  - Reset mid-operation aborts any busy count immediately.
- FSM states: IDLE, MD_BUSY.
  - IDLE + E_md_start: busy_cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES; go to MD_BUSY.
  - MD_BUSY: busy_cnt decrements by 1 each edge; when busy_cnt==1, next state is IDLE and busy_cnt becomes 0.
  - MD_BUSY + E_md_start: counter reloads with the new value and the state stays MD_BUSY. This is unreachable when the hazard logic is correct, but it is the defined behaviour.
- md_busy = (state==MD_BUSY); equivalently busy_cnt!=0.
- Load-use hazard (combinational) is true when all of the following hold:
  - E_load, E_regwrite, and E_wa!=0;
  - and (D_use_rs and D_rs==E_wa) or (D_use_rt and D_rt==E_wa).
- Writes to $0 never cause a hazard.
- MD hazard (combinational) = md_busy and D_md_use. It does not depend on E_md_start in the same cycle; the D instruction is checked against registered state only.
- stall = load_use or md_hazard (combinational, zero latency); flush_e = stall.
- Load-use stall lasts exactly 1 cycle, because the bubble removes the load's E match on the next cycle.
- MD stall latency: a dependent instruction entering D the cycle after mult issues stalls for exactly MULT_CYCLES cycles. For div it stalls exactly DIV_CYCLES cycles.
- Simultaneous load-use and MD hazard: a single stall is asserted, and stall_cycles increments once.
- stall_cycles increments on each clock edge where stall=1 and saturates at all-ones; no wrap-around.

Test Plan:
- Reset check: hold reset=0 while driving a load-use match (E_load=1, E_regwrite=1, E_wa=8, D_rs=8, D_use_rs=1) -> stall=0, flush_e=0, busy_cnt=0. Release reset -> stall=1 in the same cycle.
- Load-use on rt: E_load=1, E_wa=9, D_rt=9, D_use_rt=1 for one cycle, then a bubble in E -> stall high for exactly 1 cycle and stall_cycles=1. Repeat with E_wa=0 -> stall never asserts.
- Mult dependency: pulse E_md_start=1, E_md_is_div=0, then hold D_md_use=1 -> busy_cnt reads 5,4,3,2,1,0 and stall is high for exactly 5 cycles; stall_cycles=5.
- Div with reset mid-operation: start a div, assert reset=0 asynchronously when busy_cnt=6 -> md_busy=0, busy_cnt=0, stall=0 immediately; after release the state is IDLE.
- Overlap: div busy with busy_cnt=3, D_md_use=1, plus a load-use match -> single stall asserted; stall_cycles increments by 1 per cycle.
- Saturation: PERF_W=4 with stall held for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Load-use and HI/LO-unit hazard detection for the 5-stage MIPS
//            pipeline; drives stall/flush_e and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic              D_use_rs,
  input  logic              D_use_rt,
  input  logic              D_md_use,
  input  logic              E_load,
  input  logic              E_regwrite,
  input  logic [4:0]        E_wa,
  input  logic              E_md_start,
  input  logic              E_md_is_div,
  output logic              stall,
  output logic              flush_e,
  output logic              md_busy,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [0:0]        c_st_idle    = 1'b0;
  localparam logic [0:0]        c_st_md_busy = 1'b1;
  localparam logic [CNT_W-1:0]  c_mult_load  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0]  c_div_load   = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  c_cnt_zero   = '0;
  localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);
  localparam logic [PERF_W-1:0] c_perf_one   = PERF_W'(1);
  localparam logic [PERF_W-1:0] c_perf_max   = '1;
  localparam logic [4:0]        c_reg_zero   = 5'd0;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_busy_cnt;
  logic [CNT_W-1:0]  w_busy_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              w_md_busy;
  logic              w_load_use;
  logic              w_md_hazard;
  logic              w_stall;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_st_idle;
      r_busy_cnt <= c_cnt_zero;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  // Next-state logic; a new start while busy reloads the counter
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    case (r_state)
      c_st_idle: begin
        if (E_md_start) begin
          w_state_nxt    = c_st_md_busy;
          w_busy_cnt_nxt = E_md_is_div ? c_div_load : c_mult_load;
        end
      end
      c_st_md_busy: begin
        if (E_md_start) begin
          w_busy_cnt_nxt = E_md_is_div ? c_div_load : c_mult_load;
        end else if (r_busy_cnt == c_cnt_one) begin
          w_state_nxt    = c_st_idle;
          w_busy_cnt_nxt = c_cnt_zero;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt - c_cnt_one;
        end
      end
      default: begin
        w_state_nxt    = c_st_idle;
        w_busy_cnt_nxt = c_cnt_zero;
      end
    endcase
  end

  // Output logic; reset gating keeps stall low even with hazard inputs active
  always_comb begin
    w_md_busy   = (r_state == c_st_md_busy);
    w_load_use  = E_load && E_regwrite && (E_wa != c_reg_zero) &&
                  ((D_use_rs && (D_rs == E_wa)) || (D_use_rt && (D_rt == E_wa)));
    w_md_hazard = w_md_busy && D_md_use;
    w_stall     = reset && (w_load_use || w_md_hazard);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != c_perf_max)) begin
      r_stall_cycles <= r_stall_cycles + c_perf_one;
    end
  end

  assign stall        = w_stall;
  assign flush_e      = w_stall;
  assign md_busy      = w_md_busy;
  assign busy_cnt     = r_busy_cnt;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
